// File: rtl/global_buffer_sequencer.sv
// Purpose: command sequencer for the global buffer (pointer setup, instruction strobe, counted write/read bursts).
// Latency: accept -> ISSUE next cycle; first gb_rd_en the cycle after ISSUE; read data reaches m_valid via a 2-entry FIFO.
// Backpressure: writes stall on s_valid/gb_wr_ready; reads are throttled so FIFO occupancy plus the in-flight read never exceeds 2.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/
//   cmd_addr/cmd_len                  command channel (one command in flight, ready only in IDLE)
//   weight_start_addr,
//   activation_start_addr             registered start-address pointers
//   gb_instr/gb_instr_valid           one-cycle instruction strobe
//   gb_wr_data/gb_wr_en/gb_wr_ready   buffer write port
//   gb_rd_en/gb_rd_data/
//   gb_rd_data_valid                  buffer read port (fixed one-cycle read latency)
//   s_valid/s_ready/s_data            write-data input stream
//   m_valid/m_ready/m_data            read-data output stream
//   busy/op_done/cmd_err              status
module global_buffer_sequencer #(
    parameter int addrWidth      = 32,
    parameter int dataSize       = 8,
    parameter int interfaceDepth = 16,
    parameter int lenWidth       = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [3:0]                           cmd_op,
    input  logic [addrWidth-1:0]                 cmd_addr,
    input  logic [lenWidth-1:0]                  cmd_len,
    output logic [addrWidth-1:0]                 weight_start_addr,
    output logic [addrWidth-1:0]                 activation_start_addr,
    output logic [3:0]                           gb_instr,
    output logic                                 gb_instr_valid,
    output logic [interfaceDepth*dataSize-1:0]   gb_wr_data,
    output logic                                 gb_wr_en,
    input  logic                                 gb_wr_ready,
    output logic                                 gb_rd_en,
    input  logic [interfaceDepth*dataSize-1:0]   gb_rd_data,
    input  logic                                 gb_rd_data_valid,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [interfaceDepth*dataSize-1:0]   s_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [interfaceDepth*dataSize-1:0]   m_data,
    output logic                                 busy,
    output logic                                 op_done,
    output logic                                 cmd_err
);

    localparam int W = interfaceDepth * dataSize;

    localparam logic [3:0] OP_PTR_RST = 4'd1;
    localparam logic [3:0] OP_LD_W    = 4'd2;
    localparam logic [3:0] OP_LD_A    = 4'd3;
    localparam logic [3:0] OP_RD_A    = 4'd5;

    localparam logic [lenWidth-1:0] LEN_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          op_q;
    logic [lenWidth-1:0] len_q;
    logic [lenWidth-1:0] wr_cnt;
    logic [lenWidth-1:0] rd_issued;
    logic [lenWidth-1:0] rd_popped;
    logic                inflight;

    // 2-entry output FIFO
    logic [W-1:0]        fifo_mem [2];
    logic                fifo_rd_ptr;
    logic                fifo_wr_ptr;
    logic [1:0]          fifo_cnt;

    logic                accept;
    logic                wr_fire;
    logic                push;
    logic                pop;
    logic [2:0]          occ;

    assign accept     = cmd_valid && cmd_ready;
    assign wr_fire    = gb_wr_en && gb_wr_ready;
    assign gb_wr_data = s_data;
    assign m_data     = fifo_mem[fifo_rd_ptr];
    assign m_valid    = (state == S_READ) && (fifo_cnt != 2'd0);
    assign pop        = m_valid && m_ready;
    // Read data arriving without a matching request is stray and dropped.
    assign push       = gb_rd_data_valid && inflight;
    assign occ        = {1'b0, fifo_cnt} + {2'b00, inflight};

    // A new read is allowed only if the word it returns is guaranteed a FIFO
    // slot: current entries plus the one already in flight, minus the one
    // leaving this cycle, must be below 2.
    assign gb_rd_en = (state == S_READ) && (rd_issued < len_q) &&
                      (occ < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_nxt      = state;
        cmd_ready      = 1'b0;
        busy           = 1'b1;
        gb_instr_valid = 1'b0;
        gb_instr       = 4'd0;
        gb_wr_en       = 1'b0;
        s_ready        = 1'b0;
        op_done        = 1'b0;
        cmd_err        = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_op >= OP_PTR_RST && cmd_op <= OP_RD_A)
                        state_nxt = S_ISSUE;
                    else
                        state_nxt = S_DONE;
                end
            end
            S_ISSUE: begin
                gb_instr_valid = 1'b1;
                gb_instr       = op_q;
                if (len_q == '0 || op_q == OP_PTR_RST)
                    state_nxt = S_DONE;
                else if (op_q == OP_RD_A)
                    state_nxt = S_READ;
                else
                    state_nxt = S_WRITE;
            end
            S_WRITE: begin
                gb_wr_en = s_valid;
                s_ready  = gb_wr_ready;
                if (s_valid && gb_wr_ready && (wr_cnt + LEN_ONE) == len_q)
                    state_nxt = S_DONE;
            end
            S_READ: begin
                if (pop && (rd_popped + LEN_ONE) == len_q)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                op_done   = 1'b1;
                cmd_err   = (op_q > OP_RD_A);
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= S_IDLE;
            op_q                  <= 4'd0;
            len_q                 <= '0;
            wr_cnt                <= '0;
            rd_issued             <= '0;
            rd_popped             <= '0;
            inflight              <= 1'b0;
            fifo_rd_ptr           <= 1'b0;
            fifo_wr_ptr           <= 1'b0;
            fifo_cnt              <= 2'd0;
            weight_start_addr     <= '0;
            activation_start_addr <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= gb_rd_en;

            if (accept) begin
                op_q      <= cmd_op;
                len_q     <= cmd_len;
                wr_cnt    <= '0;
                rd_issued <= '0;
                rd_popped <= '0;
                case (cmd_op)
                    OP_PTR_RST: begin
                        weight_start_addr     <= '0;
                        activation_start_addr <= '0;
                    end
                    OP_LD_W:          weight_start_addr     <= cmd_addr;
                    OP_LD_A, OP_RD_A: activation_start_addr <= cmd_addr;
                    default: ;
                endcase
            end else begin
                if (wr_fire)  wr_cnt    <= wr_cnt + LEN_ONE;
                if (gb_rd_en) rd_issued <= rd_issued + LEN_ONE;
                if (pop)      rd_popped <= rd_popped + LEN_ONE;
            end

            if (push) fifo_wr_ptr <= ~fifo_wr_ptr;
            if (pop)  fifo_rd_ptr <= ~fifo_rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[fifo_wr_ptr] <= gb_rd_data;
    end

endmodule
